// File: rtl/mem_arb_pkg.sv
// Shared widths and index-sizing helper for the memory arbiter and its tag FIFO.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 48;
    localparam int DATA_W_DEF = 64;

    // A core index needs at least one bit even when only one port is present.
    function automatic int core_idx_w(input int num_cores);
        return (num_cores <= 1) ? 1 : $clog2(num_cores);
    endfunction

endpackage

// File: rtl/mem_arbiter_tag_fifo.sv
// In-order FIFO of issuing-core indices for outstanding reads.
// Latency: a pushed entry reaches the head one cycle later; head data is read combinationally.
// Backpressure: push dropped when full unless a same-cycle pop frees the slot; pop ignored when empty.
module tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign pop_dat = store[rd_ptr];

    // Pointers wrap naturally at DEPTH; the count alone separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter from NUM_CORES engine ports onto one memory port, routing read data back by tag.
// Latency: grant and memory request are combinational; read data reaches the core 1 cycle after mem_rvalid.
// Backpressure: mem_ready gates grants; reads stall while TAG_DEPTH reads are in flight, writes never stall.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TAG_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_we,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_gnt,
    output logic [NUM_CORES-1:0]          core_valid,
    output logic [DATA_W-1:0]             core_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_orphan
);

    localparam int IDX_W = core_idx_w(NUM_CORES);

    logic [NUM_CORES-1:0] elig;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     head;
    logic                 found;
    logic                 hs;
    logic                 tag_push;
    logic                 tag_pop;
    logic                 tag_full;
    logic                 tag_empty;
    int                   scan_idx;

    // Full is taken from the registered count so mem_rvalid never feeds mem_req.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            elig[i] = core_req[i] & (core_we[i] | ~tag_full);
        end
    end

    always_comb begin
        winner   = rr_ptr;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_CORES) scan_idx = scan_idx - NUM_CORES;
            if (!found && elig[scan_idx]) begin
                winner = IDX_W'(scan_idx);
                found  = 1'b1;
            end
        end
    end

    assign mem_req   = found;
    assign hs        = mem_req & mem_ready;
    assign mem_we    = found & core_we[winner];
    assign mem_addr  = found ? core_addr[winner*ADDR_W +: ADDR_W]  : '0;
    assign mem_wdata = found ? core_wdata[winner*DATA_W +: DATA_W] : '0;

    always_comb begin
        core_gnt = '0;
        if (hs) core_gnt[winner] = 1'b1;
    end

    assign tag_push = hs & ~mem_we;
    assign tag_pop  = mem_rvalid & ~tag_empty;

    tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tag_push),
        .push_dat (winner),
        .pop      (tag_pop),
        .pop_dat  (head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (outstanding)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            core_valid <= '0;
            core_rdata <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (hs) rr_ptr <= (winner == IDX_W'(NUM_CORES - 1)) ? '0 : winner + 1'b1;
            core_valid <= '0;
            if (tag_pop) begin
                core_valid[head] <= 1'b1;
                core_rdata       <= mem_rdata;
            end
            if (mem_rvalid & tag_empty) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: reference arbiter model, latency-programmable memory model.
module tb_mem_arbiter;

    localparam int NC   = 4;
    localparam int AW   = 48;
    localparam int DW   = 64;
    localparam int TD   = 16;
    localparam int LAT  = 3;
    localparam int BIG  = 1000000;

    typedef struct { int core; logic [63:0] data; } sb_t;
    typedef struct { int due;  logic [63:0] data; } mq_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NC-1:0]       core_req, core_we, core_gnt, core_valid;
    logic [NC*AW-1:0]    core_addr;
    logic [NC*DW-1:0]    core_wdata;
    logic [DW-1:0]       core_rdata, mem_wdata, mem_rdata;
    logic                mem_req, mem_we, mem_ready, mem_rvalid, err_orphan;
    logic [AW-1:0]       mem_addr;
    logic [4:0]          outstanding;

    mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_valid(core_valid),
        .core_rdata(core_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .outstanding(outstanding), .err_orphan(err_orphan));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // engine stimulus
    int          beats_left [NC];
    logic [AW-1:0] addr_drv [NC];
    bit          is_wr [NC];
    int          mem_credits = 0;

    // reference model state
    int          m_cnt = 0;
    int          m_rr = 0;
    logic [3:0]  m_vld = '0;
    logic [63:0] m_rdata = '0;
    bit          m_orphan = 0;
    sb_t         sb [$];
    mq_t         mem_q [$];

    // observations from the latest negedge
    logic [3:0]  obs_gnt, obs_vld;
    logic [4:0]  obs_out;
    logic        obs_err;
    logic [3:0]  gnt_log [$];
    int          act_gnt [NC];
    int          act_vld [NC];
    int          peak;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mkdata(input logic [AW-1:0] a);
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    function automatic logic [63:0] wdata_of(input logic [AW-1:0] a);
        return {16'hC0DE, a};
    endfunction

    function automatic bit any_busy();
        for (int i = 0; i < NC; i++) if (beats_left[i] > 0) return 1;
        return 0;
    endfunction

    task automatic drive();
        mq_t m;
        for (int i = 0; i < NC; i++) begin
            core_req[i] = (beats_left[i] > 0);
            core_we[i]  = is_wr[i];
            core_addr[i*AW +: AW]  = addr_drv[i];
            core_wdata[i*DW +: DW] = wdata_of(addr_drv[i]);
        end
        if (!rst && mem_credits > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = m.data;
            mem_credits--;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
        end
    endtask

    task automatic cycle();
        sb_t         e;
        mq_t         m;
        logic [3:0]  exp_gnt;
        bit          exp_req, hs, popped, pushed;
        int          win, c;
        @(negedge clk);
        obs_gnt = core_gnt; obs_out = outstanding; obs_vld = core_valid; obs_err = err_orphan;
        if (core_gnt != 0) gnt_log.push_back(core_gnt);
        for (int i = 0; i < NC; i++) begin
            if (core_gnt[i])   act_gnt[i]++;
            if (core_valid[i]) act_vld[i]++;
        end
        if (int'(outstanding) > peak) peak = int'(outstanding);
        check("outstanding", outstanding, m_cnt);
        check("core_valid", core_valid, m_vld);
        check("core_rdata", core_rdata, m_rdata);
        check("err_orphan", err_orphan, m_orphan);
        exp_req = 0; win = 0;
        for (int k = 0; k < NC; k++) begin
            c = (m_rr + k) % NC;
            if (!exp_req && beats_left[c] > 0 && (is_wr[c] || m_cnt < TD)) begin
                exp_req = 1; win = c;
            end
        end
        hs = exp_req && mem_ready;
        exp_gnt = '0;
        if (hs) exp_gnt[win] = 1'b1;
        check("mem_req", mem_req, exp_req);
        check("core_gnt", core_gnt, exp_gnt);
        if (exp_req) begin
            check("mem_addr", mem_addr, addr_drv[win]);
            check("mem_we", mem_we, is_wr[win]);
            if (is_wr[win]) check("mem_wdata", mem_wdata, wdata_of(addr_drv[win]));
        end else begin
            check("mem_addr_idle", mem_addr, 0);
        end
        // memory answers whatever the bus actually issued
        if (mem_req && mem_ready && !mem_we) begin
            m.due = cyc + LAT; m.data = mkdata(mem_addr);
            mem_q.push_back(m);
        end
        if (rst) begin
            m_cnt = 0; m_rr = 0; m_vld = '0; m_rdata = '0; m_orphan = 0; sb.delete();
        end else begin
            popped = mem_rvalid && m_cnt > 0;
            pushed = hs && !is_wr[win];
            if (mem_rvalid && m_cnt == 0) m_orphan = 1;
            m_vld = '0;
            if (popped) begin
                e = sb.pop_front();
                m_vld[e.core] = 1'b1;
                m_rdata = e.data;
            end
            if (hs) m_rr = (win + 1) % NC;
            if (pushed) begin
                e.core = win; e.data = mkdata(addr_drv[win]);
                sb.push_back(e);
            end
            m_cnt = m_cnt + int'(pushed) - int'(popped);
        end
        if (hs) begin
            beats_left[win]--;
            addr_drv[win] = addr_drv[win] + 8;
        end
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive();
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic clear_stats();
        gnt_log.delete();
        peak = 0;
        for (int i = 0; i < NC; i++) begin
            act_gnt[i] = 0; act_vld[i] = 0; beats_left[i] = 0; is_wr[i] = 0;
        end
    endtask

    task automatic run_idle(input string tag, input int max);
        int n = 0;
        while ((any_busy() || m_cnt != 0 || m_vld != 0) && n < max) begin
            cycle();
            n++;
        end
        check(tag, int'(any_busy() || m_cnt != 0 || m_vld != 0), 0);
    endtask

    initial begin
        logic [3:0] exp_oh;
        rst = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < NC; i++) begin
            beats_left[i] = 0; addr_drv[i] = '0; is_wr[i] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        do_reset(2);
        check("rst_valid", obs_vld, 0);
        check("rst_out", obs_out, 0);
        check("rst_err", obs_err, 0);

        // single core, 4 reads, 3-cycle memory
        clear_stats(); mem_q.delete(); mem_credits = BIG;
        beats_left[0] = 4; addr_drv[0] = 48'h1000;
        drive();
        run_idle("t1_idle", 60);
        check("t1_gnts", act_gnt[0], 4);
        check("t1_vld", act_vld[0], 4);
        check("t1_peak", peak, 3);
        check("t1_out_end", obs_out, 0);

        // all four cores reading, round-robin from 0
        do_reset(2); clear_stats(); mem_q.delete();
        for (int i = 0; i < NC; i++) begin
            beats_left[i] = 8; addr_drv[i] = 48'h2000 + 48'(i * 256);
        end
        drive();
        run_idle("t2_idle", 200);
        for (int i = 0; i < 8; i++) begin
            exp_oh = '0; exp_oh[i % NC] = 1'b1;
            check("t2_order", (gnt_log.size() > i) ? gnt_log[i] : 4'h0, exp_oh);
        end
        for (int i = 0; i < NC; i++) check("t2_vld", act_vld[i], 8);

        // tag FIFO fills: reads stall, writes continue
        do_reset(2); clear_stats(); mem_q.delete(); mem_credits = 0;
        beats_left[1] = 20; addr_drv[1] = 48'h3000;
        beats_left[2] = 20; addr_drv[2] = 48'h4000; is_wr[2] = 1;
        drive();
        repeat (40) cycle();
        check("t3_rd_gnts", act_gnt[1], 16);
        check("t3_wr_gnts", act_gnt[2], 20);
        check("t3_out_full", obs_out, 16);

        // full FIFO with rvalid and pending read: pop only, read granted next cycle
        mem_credits = 1;
        cycle();
        cycle();
        check("t5_blk_gnt", obs_gnt, 4'b0000);
        check("t5_out16", obs_out, 16);
        cycle();
        check("t5_out15", obs_out, 15);
        check("t5_gnt", obs_gnt, 4'b0010);
        cycle();
        check("t5_out_back", obs_out, 16);
        check("t5_rd_gnts", act_gnt[1], 17);
        mem_credits = BIG;
        run_idle("t3_idle", 150);
        check("t3_vld", act_vld[1], 20);

        // mem_ready low holds everything back
        do_reset(2); clear_stats(); mem_q.delete(); mem_credits = BIG;
        beats_left[3] = 1; addr_drv[3] = 48'h5000; mem_ready = 1'b0;
        drive();
        repeat (5) cycle();
        check("t4_no_gnt", gnt_log.size(), 0);
        check("t4_no_push", obs_out, 0);
        mem_ready = 1'b1;
        cycle();
        check("t4_gnt", obs_gnt, 4'b1000);
        run_idle("t4_idle", 30);

        // reset with reads in flight, then stale responses become orphans
        do_reset(2); clear_stats(); mem_q.delete(); mem_credits = 0;
        beats_left[0] = 5; addr_drv[0] = 48'h6000;
        drive();
        repeat (8) cycle();
        check("t6_out5", obs_out, 5);
        do_reset(2);
        mem_credits = 5;
        drive();
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t6_err", obs_err, (i >= 1) ? 1 : 0);
            check("t6_vld", obs_vld, 0);
            check("t6_out", obs_out, 0);
        end
        do_reset(2);
        check("t6_err_clr", obs_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the NTT engine cores, between NUM_CORES engine arbiter interfaces and a single shared memory/DMA port.
- Grants one beat per cycle using round-robin arbitration.
- Tracks the issuing core of every outstanding read in an in-order tag FIFO and routes each read response back to that core.
- Each engine sees a request/grant/valid protocol with one beat per grant and in-order read data.

Parameters:
- NUM_CORES, 4, number of engine ports (≥2).
- ADDR_W, 48, byte address width.
- DATA_W, 64, data word width.
- TAG_DEPTH, 16, maximum outstanding reads (power of 2).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- core_req  in  NUM_CORES  per-core request, held until granted.
- core_we  in  NUM_CORES  per-core write enable.
- core_addr  in  NUM_CORES*ADDR_W  packed addresses; core i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  packed write data.
- core_gnt  out  NUM_CORES  one-hot grant, combinational.
- core_valid  out  NUM_CORES  one-hot read-data valid, registered.
- core_rdata  out  DATA_W  read data, broadcast to all cores, registered.
- mem_req  out  1  memory request, combinational.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts the beat this cycle.
- mem_rvalid  in  1  read response, in issue order.
- mem_rdata  in  DATA_W  read response data.
- outstanding  out  $clog2(TAG_DEPTH)+1  reads in flight.
- err_orphan  out  1  sticky: mem_rvalid arrived while the tag FIFO was empty.

Behaviour:
- Reset:
  - rr_ptr=0; tag FIFO empty; outstanding=0.
  - core_valid=0; core_rdata=0; err_orphan=0.
  - Reset mid-traffic discards all in-flight tags. Responses after reset with an empty FIFO set err_orphan.
- Eligibility: core i is eligible when core_req[i]=1 and NOT (core_we[i]=0 AND tag FIFO full). Writes are never blocked by a full FIFO.
- Winner: first eligible core scanning rr_ptr, rr_ptr+1, … modulo NUM_CORES.
- Memory request:
  - mem_req = any eligible core.
  - mem_we, mem_addr and mem_wdata are muxed from the winner; all are 0 when there is no winner.
- Grant:
  - core_gnt[winner] = mem_req & mem_ready, in the same cycle (zero latency). Otherwise all grant bits are 0.
  - A core advances its beat counter on core_gnt.
- Handshake (mem_req & mem_ready):
  - rr_ptr <= (winner+1) mod NUM_CORES.
  - If the beat is a read, push the winner index into the tag FIFO.
  - With no handshake, rr_ptr holds.
- Response (mem_rvalid):
  - Pop the FIFO head h.
  - Next cycle: core_valid <= onehot(h) and core_rdata <= mem_rdata. Latency is exactly 1 cycle.
  - When mem_rvalid=0: core_valid <= 0 and core_rdata holds.
- Orphan response: mem_rvalid with the FIFO empty → no pop, core_valid stays 0, err_orphan <= 1 until rst.
- Simultaneous push and pop:
  - Legal, including when the FIFO is full, because a pop in the same cycle frees the entry.
  - Full-blocking uses the registered count, so a read is blocked when full even if a pop occurs in the same cycle. This is conservative and avoids a combinational path from mem_rvalid to mem_req.
  - outstanding = push − pop, updated every cycle.
- Wrap: FIFO read/write pointers wrap modulo TAG_DEPTH; the count distinguishes full from empty.
- Fairness: a continuously requesting core receives at least one grant every NUM_CORES handshakes.

Decomposition:
- Shared package mem_arb_pkg: ADDR_W and DATA_W defaults, CORE_IDX_W function/constant.
- Sub-module tag_fifo: synchronous FIFO of core indices with push/pop/full/empty/count and same-cycle push+pop.
- Round-robin select and output muxing stay in mem_arbiter.

Test Plan:
- Single core 0 reads 4 beats at addr 0x1000, memory with 3-cycle latency, mem_ready=1 → core_gnt[0] for 4 consecutive cycles; mem_addr = 0x1000, 0x1008, 0x1010, 0x1018; core_valid[0] 4 times with data in order; outstanding peaks at 3 and returns to 0.
- All 4 cores requesting reads continuously, rr_ptr=0 → grant order 0,1,2,3,0,1…; each response's core_valid bit matches the issuing core.
- TAG_DEPTH=16, memory withholds rvalid, core 1 reading, core 2 writing → 16 read grants then reads blocked with outstanding=16; core 2 writes still granted; first rvalid unblocks exactly one read.
- mem_ready=0 for 5 cycles with core 3 requesting → core_gnt=0, rr_ptr unchanged, no FIFO push; grant appears on the first mem_ready=1 cycle.
- Full FIFO with simultaneous rvalid and new read request → pop only, count 16→15; read granted next cycle, count back to 16.
- rst asserted with 5 reads outstanding, then 5 mem_rvalid pulses → outstanding=0 and core_valid=0 throughout; err_orphan=1 after the first pulse and stays set until the next rst.
